// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types for the frame-synchronous overlay blocks.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int H_TOTAL   = 800;
    localparam int V_TOTAL   = 525;
    localparam int COORD_W   = 10;

    typedef enum logic {
        EMPTY   = 1'b0,
        PENDING = 1'b1
    } sched_state_t;

    typedef enum logic {
        SRC_LIVE = 1'b0,
        SRC_OVR  = 1'b1
    } coord_src_t;

endpackage

// File: rtl/vblank_detect.sv
// One-cycle pulse marking the first pixel of the first non-visible line.
module vblank_detect #(
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE
) (
    input  logic       MAX10_CLK1_50,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic [9:0] counterX,
    input  logic [9:0] counterY,
    output logic       vblank_pulse
);

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset)
            vblank_pulse <= 1'b0;
        else
            vblank_pulse <= pix_ce && (counterX == 10'd0) && (counterY == 10'(V_VISIBLE));
    end

endmodule

// File: rtl/vga_coord_scheduler.sv
// Arbitrates live/override coordinate updates and commits one per frame at vblank start.
//   state   | meaning
//   EMPTY   | staging register free, requesters may transfer
//   PENDING | staging register full, waiting for vblank_pulse to commit
module vga_coord_scheduler #(
    parameter int V_VISIBLE   = vga_pkg::V_VISIBLE,
    parameter int COORD_W     = vga_pkg::COORD_W,
    parameter int HOLD_FRAMES = 30
) (
    input  logic               MAX10_CLK1_50,
    input  logic               reset,
    input  logic               pix_ce,
    input  logic [9:0]         counterX,
    input  logic [9:0]         counterY,
    input  logic               live_valid,
    output logic               live_ready,
    input  logic [COORD_W-1:0] live_x,
    input  logic [COORD_W-1:0] live_y,
    input  logic [COORD_W-1:0] live_z,
    input  logic               ovr_valid,
    output logic               ovr_ready,
    input  logic [COORD_W-1:0] ovr_x,
    input  logic [COORD_W-1:0] ovr_y,
    input  logic [COORD_W-1:0] ovr_z,
    output logic [COORD_W-1:0] disp_x,
    output logic [COORD_W-1:0] disp_y,
    output logic [COORD_W-1:0] disp_z,
    output logic               disp_src_ovr,
    output logic               commit_pulse,
    output logic               busy,
    output logic               hold_active
);
    import vga_pkg::*;

    sched_state_t       state_q, state_d;
    logic [COORD_W-1:0] stage_x, stage_y, stage_z;
    coord_src_t         stage_src;
    logic [7:0]         hold_cnt;
    logic               vblank_pulse;
    logic               ovr_xfer, live_xfer, accept, commit;

    vblank_detect #(
        .V_VISIBLE (V_VISIBLE)
    ) u_vblank (
        .MAX10_CLK1_50 (MAX10_CLK1_50),
        .reset         (reset),
        .pix_ce        (pix_ce),
        .counterX      (counterX),
        .counterY      (counterY),
        .vblank_pulse  (vblank_pulse)
    );

    // Override wins outright; a live transfer during hold is taken but dropped.
    always_comb begin
        state_d    = state_q;
        ovr_ready  = (state_q == EMPTY);
        live_ready = (state_q == EMPTY) && !ovr_valid;
        ovr_xfer   = ovr_valid && ovr_ready;
        live_xfer  = live_valid && live_ready;
        accept     = ovr_xfer || (live_xfer && (hold_cnt == 8'd0));
        commit     = (state_q == PENDING) && vblank_pulse;
        case (state_q)
            EMPTY:   if (accept) state_d = PENDING;
            PENDING: if (commit) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            state_q      <= EMPTY;
            stage_x      <= '0;
            stage_y      <= '0;
            stage_z      <= '0;
            stage_src    <= SRC_LIVE;
            disp_x       <= '0;
            disp_y       <= '0;
            disp_z       <= '0;
            disp_src_ovr <= 1'b0;
            hold_cnt     <= 8'd0;
            commit_pulse <= 1'b0;
        end else begin
            state_q      <= state_d;
            commit_pulse <= commit;
            if (accept) begin
                if (ovr_xfer) begin
                    stage_x   <= ovr_x;
                    stage_y   <= ovr_y;
                    stage_z   <= ovr_z;
                    stage_src <= SRC_OVR;
                end else begin
                    stage_x   <= live_x;
                    stage_y   <= live_y;
                    stage_z   <= live_z;
                    stage_src <= SRC_LIVE;
                end
            end
            if (commit) begin
                disp_x       <= stage_x;
                disp_y       <= stage_y;
                disp_z       <= stage_z;
                disp_src_ovr <= (stage_src == SRC_OVR);
            end
            if (commit && (stage_src == SRC_OVR))
                hold_cnt <= 8'(HOLD_FRAMES);
            else if (vblank_pulse && (hold_cnt != 8'd0))
                hold_cnt <= hold_cnt - 8'd1;
        end
    end

    assign busy        = (state_q == PENDING);
    assign hold_active = (hold_cnt != 8'd0);

endmodule

// File: tb/tb_vga_coord_scheduler.sv
// Directed bench for vga_coord_scheduler; counters are driven directly to place vblank.
module tb_vga_coord_scheduler;

    logic       MAX10_CLK1_50 = 1'b0;
    logic       reset = 1'b1;
    logic       pix_ce = 1'b0;
    logic [9:0] counterX = 10'd5;
    logic [9:0] counterY = 10'd10;
    logic       live_valid = 1'b0, ovr_valid = 1'b0;
    logic [9:0] live_x = '0, live_y = '0, live_z = '0;
    logic [9:0] ovr_x = '0, ovr_y = '0, ovr_z = '0;
    logic       live_ready, ovr_ready;
    logic [9:0] disp_x, disp_y, disp_z;
    logic       disp_src_ovr, commit_pulse, busy, hold_active;

    int n_assert = 0;
    int n_fail   = 0;

    vga_coord_scheduler #(
        .V_VISIBLE   (480),
        .COORD_W     (10),
        .HOLD_FRAMES (3)
    ) dut (
        .MAX10_CLK1_50 (MAX10_CLK1_50),
        .reset         (reset),
        .pix_ce        (pix_ce),
        .counterX      (counterX),
        .counterY      (counterY),
        .live_valid    (live_valid),
        .live_ready    (live_ready),
        .live_x        (live_x),
        .live_y        (live_y),
        .live_z        (live_z),
        .ovr_valid     (ovr_valid),
        .ovr_ready     (ovr_ready),
        .ovr_x         (ovr_x),
        .ovr_y         (ovr_y),
        .ovr_z         (ovr_z),
        .disp_x        (disp_x),
        .disp_y        (disp_y),
        .disp_z        (disp_z),
        .disp_src_ovr  (disp_src_ovr),
        .commit_pulse  (commit_pulse),
        .busy          (busy),
        .hold_active   (hold_active)
    );

    always #5 MAX10_CLK1_50 = ~MAX10_CLK1_50;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge MAX10_CLK1_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input int x, input int y, input int z);
        chk({tag, "_x"}, 32'(disp_x), 32'(x));
        chk({tag, "_y"}, 32'(disp_y), 32'(y));
        chk({tag, "_z"}, 32'(disp_z), 32'(z));
    endtask

    // Present the qualifying pixel for one edge; vblank_pulse is high in the cycle after.
    task automatic vb_arm();
        pix_ce = 1'b1; counterX = 10'd0; counterY = 10'd480;
        tick();
        pix_ce = 1'b0; counterX = 10'd1;
    endtask

    initial begin
        // reset
        tick(); tick();
        chk_disp("rst_disp", 0, 0, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_hold", 32'(hold_active), 0);
        chk("rst_commit", 32'(commit_pulse), 0);
        chk("rst_src", 32'(disp_src_ovr), 0);
        chk("rst_ovr_ready", 32'(ovr_ready), 1);
        reset = 1'b0;
        tick();

        // live update mid-frame
        live_x = 10'd100; live_y = 10'd200; live_z = 10'd300; live_valid = 1'b1;
        #1;
        chk("live_ready_empty", 32'(live_ready), 1);
        tick();
        live_valid = 1'b0;
        chk("live_busy", 32'(busy), 1);
        chk("live_disp_hold", 32'(disp_x), 0);
        // near misses on the vblank qualifier must not commit
        pix_ce = 1'b1; counterX = 10'd1; counterY = 10'd480; tick();
        pix_ce = 1'b1; counterX = 10'd0; counterY = 10'd479; tick();
        pix_ce = 1'b0; counterX = 10'd0; counterY = 10'd480; tick();
        counterX = 10'd7; tick();
        chk("nearmiss_busy", 32'(busy), 1);
        chk("nearmiss_disp", 32'(disp_x), 0);
        vb_arm();
        chk("pre_commit_disp", 32'(disp_x), 0);
        chk("pre_commit_pulse", 32'(commit_pulse), 0);
        tick();
        chk_disp("live_commit", 100, 200, 300);
        chk("live_src", 32'(disp_src_ovr), 0);
        chk("live_commit_pulse", 32'(commit_pulse), 1);
        chk("live_busy_clear", 32'(busy), 0);
        tick();
        chk("pulse_one_cycle", 32'(commit_pulse), 0);

        // simultaneous live and override
        live_x = 10'd1; live_y = 10'd1; live_z = 10'd1; live_valid = 1'b1;
        ovr_x = 10'd5; ovr_y = 10'd6; ovr_z = 10'd7; ovr_valid = 1'b1;
        #1;
        chk("prio_live_ready", 32'(live_ready), 0);
        chk("prio_ovr_ready", 32'(ovr_ready), 1);
        tick();
        live_valid = 1'b0; ovr_valid = 1'b0;
        chk("prio_busy", 32'(busy), 1);
        vb_arm(); tick();
        chk_disp("ovr_commit", 5, 6, 7);
        chk("ovr_src", 32'(disp_src_ovr), 1);
        chk("ovr_hold", 32'(hold_active), 1);

        // live stream discarded for three vblanks
        live_x = 10'd11; live_y = 10'd12; live_z = 10'd13; live_valid = 1'b1;
        tick();
        chk("hold_discard_busy", 32'(busy), 0);
        chk("hold_live_ready", 32'(live_ready), 1);
        vb_arm(); tick();
        vb_arm(); tick();
        chk("hold_after2", 32'(hold_active), 1);
        vb_arm(); tick();
        chk("hold_after3", 32'(hold_active), 0);
        chk("hold_after3_busy", 32'(busy), 0);
        chk_disp("hold_disp_kept", 5, 6, 7);
        live_x = 10'd21; live_y = 10'd22; live_z = 10'd23;
        tick();
        live_valid = 1'b0;
        chk("post_hold_busy", 32'(busy), 1);
        vb_arm(); tick();
        chk_disp("post_hold_commit", 21, 22, 23);
        chk("post_hold_src", 32'(disp_src_ovr), 0);

        // two overrides in one frame
        ovr_x = 10'd40; ovr_y = 10'd41; ovr_z = 10'd42; ovr_valid = 1'b1;
        tick();
        ovr_x = 10'd50; ovr_y = 10'd51; ovr_z = 10'd52;
        #1;
        chk("ovr2_ready_low", 32'(ovr_ready), 0);
        tick();
        chk("ovr2_busy", 32'(busy), 1);
        vb_arm(); tick();
        chk_disp("ovr2_first", 40, 41, 42);
        chk("ovr2_ready_back", 32'(ovr_ready), 1);
        tick();
        ovr_valid = 1'b0;
        chk("ovr2_second_busy", 32'(busy), 1);
        vb_arm(); tick();
        chk_disp("ovr2_second", 50, 51, 52);
        chk("ovr2_src", 32'(disp_src_ovr), 1);
        for (int i = 0; i < 3; i++) begin
            vb_arm(); tick();
        end
        chk("ovr2_hold_clear", 32'(hold_active), 0);

        // live transfer on the vblank_pulse edge
        vb_arm();
        live_x = 10'd77; live_y = 10'd78; live_z = 10'd79; live_valid = 1'b1;
        #1;
        chk("edge_live_ready", 32'(live_ready), 1);
        tick();
        live_valid = 1'b0;
        chk("edge_busy", 32'(busy), 1);
        chk("edge_commit_pulse", 32'(commit_pulse), 0);
        chk_disp("edge_not_now", 50, 51, 52);
        tick(); tick();
        vb_arm(); tick();
        chk_disp("edge_next_frame", 77, 78, 79);

        // reset while pending
        live_x = 10'd9; live_y = 10'd9; live_z = 10'd9; live_valid = 1'b1;
        tick();
        live_valid = 1'b0;
        chk("rstp_busy_before", 32'(busy), 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk_disp("rstp_disp", 0, 0, 0);
        chk("rstp_busy", 32'(busy), 0);
        vb_arm(); tick();
        chk("rstp_no_commit", 32'(commit_pulse), 0);
        chk_disp("rstp_disp_after_vb", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
